// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multi-cycle controller and the RV32I datapath.
// retired_cnt exists only when CTRL_RETIRE_CNT_EN is defined.
interface multicycle_control_unit_if #(
    parameter int unsigned INSTR_WIDTH   = 32,
    parameter int unsigned ALUCTRL_WIDTH = 3
`ifdef CTRL_RETIRE_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH     = 32
`endif
);
    logic [INSTR_WIDTH-1:0]   instr;
    logic                     EQ;
    logic                     mem_ready;
    logic                     fetch_req;
    logic                     IRWrite;
    logic                     PCWrite;
    logic                     PCsrc;
    logic                     RegWrite;
    logic [ALUCTRL_WIDTH-1:0] ALUctrl;
    logic                     ALUsrc;
    logic [1:0]               ImmSrc;
    logic                     MemRead;
    logic                     MemWrite;
    logic                     ResultSrc;
    logic                     trap;
    logic [1:0]               trap_cause;
`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0]     retired_cnt;
`endif

    modport master (
        input  instr, EQ, mem_ready,
        output fetch_req, IRWrite, PCWrite, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmSrc,
               MemRead, MemWrite, ResultSrc, trap, trap_cause
`ifdef CTRL_RETIRE_CNT_EN
        ,
        output retired_cnt
`endif
    );

    modport slave (
        output instr, EQ, mem_ready,
        input  fetch_req, IRWrite, PCWrite, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmSrc,
               MemRead, MemWrite, ResultSrc, trap, trap_cause
`ifdef CTRL_RETIRE_CNT_EN
        ,
        input  retired_cnt
`endif
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with memory timeout trap.
// Optional retired-instruction counter enabled by defining CTRL_RETIRE_CNT_EN.
module multicycle_control_unit #(
    parameter int unsigned INSTR_WIDTH    = 32,
    parameter int unsigned ALUCTRL_WIDTH  = 3,
    parameter int unsigned TIMEOUT_CYCLES = 16
`ifdef CTRL_RETIRE_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH      = 32
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_unit_if.master  ctrl
);
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WaitW-1:0] WaitLimit = WaitW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StFetch, StDecode, StExecute, StMem, StWriteback, StTrap} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             trap_q;
    logic [1:0]       cause_q, cause_d;
    logic             retire;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       is_r, is_addi, is_lw, is_sw, is_beq, is_bne, legal;
    logic [2:0] alu_op;
    logic       alu_src;
    logic [1:0] imm_src;
    logic       unused_instr;

    assign opcode       = ctrl.instr[6:0];
    assign funct3       = ctrl.instr[14:12];
    assign funct7_b5    = ctrl.instr[30];
    assign unused_instr = ^ctrl.instr;

    always_comb begin
        {is_r, is_addi, is_lw, is_sw, is_beq, is_bne} = '0;
        legal   = 1'b1;
        alu_op  = 3'b000;
        alu_src = 1'b0;
        imm_src = 2'b00;
        case (opcode)
            7'b0110011: begin
                is_r = 1'b1;
                case (funct3)
                    3'b000:  alu_op = funct7_b5 ? 3'b001 : 3'b000;
                    3'b111:  alu_op = 3'b010;
                    3'b110:  alu_op = 3'b011;
                    3'b010:  alu_op = 3'b101;
                    default: legal = 1'b0;
                endcase
            end
            7'b0010011: begin is_addi = 1'b1; alu_src = 1'b1; end
            7'b0000011: begin is_lw = 1'b1; alu_src = 1'b1; end
            7'b0100011: begin is_sw = 1'b1; alu_src = 1'b1; imm_src = 2'b01; end
            7'b1100011: begin
                alu_op  = 3'b001;
                imm_src = 2'b10;
                is_beq  = (funct3 == 3'b000);
                is_bne  = (funct3 == 3'b001);
                legal   = is_beq | is_bne;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        cause_d = cause_q;
        retire  = 1'b0;
        case (state_q)
            StFetch: begin
                if (ctrl.mem_ready) begin
                    state_d = StDecode;
                end else if (wait_q == WaitLimit) begin
                    state_d = StTrap;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDecode: begin
                state_d = legal ? StExecute : StTrap;
                if (!legal) cause_d = 2'b01;
            end
            StExecute: begin
                if (is_beq | is_bne) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else if (is_lw | is_sw) begin
                    state_d = StMem;
                end else begin
                    state_d = StWriteback;
                end
            end
            StMem: begin
                if (ctrl.mem_ready) begin
                    state_d = is_lw ? StWriteback : StFetch;
                    retire  = is_sw;
                end else if (wait_q == WaitLimit) begin
                    state_d = StTrap;
                    cause_d = 2'b11;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWriteback: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            default: state_d = StTrap;
        endcase
    end

    always_comb begin
        ctrl.fetch_req = 1'b0;
        ctrl.IRWrite   = 1'b0;
        ctrl.PCWrite   = 1'b0;
        ctrl.PCsrc     = 1'b0;
        ctrl.RegWrite  = 1'b0;
        ctrl.ALUctrl   = '0;
        ctrl.ALUsrc    = 1'b0;
        ctrl.ImmSrc    = 2'b00;
        ctrl.MemRead   = 1'b0;
        ctrl.MemWrite  = 1'b0;
        ctrl.ResultSrc = 1'b0;
        // Datapath controls stay valid from EXECUTE through the end of the instruction.
        if (state_q inside {StExecute, StMem, StWriteback}) begin
            ctrl.ALUctrl = ALUCTRL_WIDTH'(alu_op);
            ctrl.ALUsrc  = alu_src;
            ctrl.ImmSrc  = imm_src;
        end
        case (state_q)
            StFetch: begin
                ctrl.fetch_req = 1'b1;
                ctrl.IRWrite   = ctrl.mem_ready;
            end
            StExecute: begin
                ctrl.PCWrite = is_beq | is_bne;
                ctrl.PCsrc   = (is_beq & ctrl.EQ) | (is_bne & ~ctrl.EQ);
            end
            StMem: begin
                ctrl.MemRead  = is_lw;
                ctrl.MemWrite = is_sw;
                ctrl.PCWrite  = is_sw & ctrl.mem_ready;
            end
            StWriteback: begin
                ctrl.RegWrite  = 1'b1;
                ctrl.PCWrite   = 1'b1;
                ctrl.ResultSrc = is_lw;
            end
            default: ;
        endcase
        if (!rst_n) begin
            ctrl.fetch_req = 1'b0;
            ctrl.IRWrite   = 1'b0;
            ctrl.PCWrite   = 1'b0;
            ctrl.RegWrite  = 1'b0;
            ctrl.MemRead   = 1'b0;
            ctrl.MemWrite  = 1'b0;
        end
    end

    assign ctrl.trap       = trap_q;
    assign ctrl.trap_cause = cause_q;

`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    assign ctrl.retired_cnt = cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
            wait_q  <= '0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
`ifdef CTRL_RETIRE_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            trap_q  <= trap_q | (state_d == StTrap);
            cause_q <= cause_d;
`ifdef CTRL_RETIRE_CNT_EN
            if (retire) cnt_q <= cnt_q + 1'b1;
`endif
        end
    end
endmodule
